// File: rtl/branch_issue_queue_pkg.sv
// Shared types for the branch issue queue: instruction/branch encodings and the queue entry layout.
package branch_issue_queue_pkg;

  // Entry fields are sized to these ceilings so that the queue can be built with any PREG_W/ROB_W up to them.
  localparam int BRQ_PREG_MAX_W = 8;
  localparam int BRQ_ROB_MAX_W  = 8;

  typedef enum logic [1:0] {
    INST_BRANCH = 2'd0,
    INST_JAL    = 2'd1,
    INST_JALR   = 2'd2,
    INST_OTHER  = 2'd3
  } inst_type_t;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'd0,
    BR_BNE  = 3'd1,
    BR_BLT  = 3'd4,
    BR_BGE  = 3'd5,
    BR_BLTU = 3'd6,
    BR_BGEU = 3'd7
  } branch_op_t;

  typedef struct packed {
    logic                      valid;
    inst_type_t                inst_type;
    branch_op_t                branch_op;
    logic [31:0]               pc;
    logic [31:0]               imm;
    logic                      pred_taken;
    logic [31:0]               pred_target;
    logic [BRQ_PREG_MAX_W-1:0] rs1;
    logic                      rs1_rdy;
    logic [BRQ_PREG_MAX_W-1:0] rs2;
    logic                      rs2_rdy;
    logic [BRQ_PREG_MAX_W-1:0] pd;
    logic [BRQ_ROB_MAX_W-1:0]  rob_idx;
  } brq_entry_t;

  function automatic logic [31:0] link_addr(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/branch_issue_queue.sv
// In-order branch issue queue: waits for operands via CDB wakeup, issues the head to an external
// branch unit and registers the resolution and link writeback one cycle later.
module branch_issue_queue
  import branch_issue_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int PREG_W = 6,
  parameter int ROB_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              disp_valid,
  output logic              disp_ready,
  input  inst_type_t        disp_inst_type,
  input  branch_op_t        disp_branch_op,
  input  logic [31:0]       disp_pc,
  input  logic [31:0]       disp_imm,
  input  logic              disp_pred_taken,
  input  logic [31:0]       disp_pred_target,
  input  logic [PREG_W-1:0] disp_rs1,
  input  logic [PREG_W-1:0] disp_rs2,
  input  logic              disp_rs1_rdy,
  input  logic              disp_rs2_rdy,
  input  logic [PREG_W-1:0] disp_pd,
  input  logic [ROB_W-1:0]  disp_rob_idx,
  input  logic              cdb_valid,
  input  logic [PREG_W-1:0] cdb_preg,
  output logic [PREG_W-1:0] prf_rs1_idx,
  output logic [PREG_W-1:0] prf_rs2_idx,
  input  logic [31:0]       prf_rs1_data,
  input  logic [31:0]       prf_rs2_data,
  input  logic              bu_taken,
  input  logic [31:0]       bu_target,
  output branch_op_t        bu_branch_op,
  output inst_type_t        bu_inst_type,
  output logic [31:0]       bu_pc,
  output logic [31:0]       bu_imm,
  output logic [31:0]       bu_rs1_data,
  output logic [31:0]       bu_rs2_data,
  output logic              res_valid,
  output logic [ROB_W-1:0]  res_rob_idx,
  output logic              res_taken,
  output logic [31:0]       res_target,
  output logic              res_mispredict,
  output logic              wb_valid,
  output logic [PREG_W-1:0] wb_preg,
  output logic [31:0]       wb_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  brq_entry_t        entries_q [DEPTH];
  brq_entry_t        entries_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              res_valid_q, res_valid_d;
  logic [ROB_W-1:0]  res_rob_idx_q, res_rob_idx_d;
  logic              res_taken_q, res_taken_d;
  logic [31:0]       res_target_q, res_target_d;
  logic              res_mispredict_q, res_mispredict_d;
  logic              wb_valid_q, wb_valid_d;
  logic [PREG_W-1:0] wb_preg_q, wb_preg_d;
  logic [31:0]       wb_data_q, wb_data_d;

  logic head_rdy_s, issue_s, disp_fire_s, mispredict_s, clear_s, is_link_s;
  logic [BRQ_PREG_MAX_W-1:0] cdb_preg_x_s;

  assign cdb_preg_x_s = BRQ_PREG_MAX_W'(cdb_preg);
  assign disp_ready   = ~rst & (count_q < CNT_W'(DEPTH));

  assign prf_rs1_idx  = entries_q[head_q].rs1[PREG_W-1:0];
  assign prf_rs2_idx  = entries_q[head_q].rs2[PREG_W-1:0];
  assign bu_branch_op = entries_q[head_q].branch_op;
  assign bu_inst_type = entries_q[head_q].inst_type;
  assign bu_pc        = entries_q[head_q].pc;
  assign bu_imm       = entries_q[head_q].imm;
  assign bu_rs1_data  = prf_rs1_data;
  assign bu_rs2_data  = prf_rs2_data;

  // A registered mispredict squashes everything in flight, exactly like an external flush.
  always_comb begin
    clear_s      = flush | res_mispredict_q;
    head_rdy_s   = entries_q[head_q].valid &
                   ((entries_q[head_q].inst_type == INST_JAL) |
                    (entries_q[head_q].rs1_rdy & entries_q[head_q].rs2_rdy));
    issue_s      = head_rdy_s & ~clear_s;
    disp_fire_s  = disp_valid & disp_ready & ~clear_s;
    mispredict_s = (bu_taken != entries_q[head_q].pred_taken) |
                   (bu_taken & (bu_target != entries_q[head_q].pred_target));
    is_link_s    = (entries_q[head_q].inst_type == INST_JAL) |
                   (entries_q[head_q].inst_type == INST_JALR);
  end

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (clear_s) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_d[i] = '0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_d[i].rs1_rdy = entries_q[i].rs1_rdy | (cdb_valid & (entries_q[i].rs1 == cdb_preg_x_s));
        entries_d[i].rs2_rdy = entries_q[i].rs2_rdy | (cdb_valid & (entries_q[i].rs2 == cdb_preg_x_s));
      end
      if (issue_s) begin
        entries_d[head_q].valid = 1'b0;
        head_d = head_q + PTR_W'(1'b1);
      end else begin
        head_d = head_q;
      end
      // Operand readiness at dispatch also catches a CDB broadcast in the same cycle.
      if (disp_fire_s) begin
        entries_d[tail_q].valid       = 1'b1;
        entries_d[tail_q].inst_type   = disp_inst_type;
        entries_d[tail_q].branch_op   = disp_branch_op;
        entries_d[tail_q].pc          = disp_pc;
        entries_d[tail_q].imm         = disp_imm;
        entries_d[tail_q].pred_taken  = disp_pred_taken;
        entries_d[tail_q].pred_target = disp_pred_target;
        entries_d[tail_q].rs1         = BRQ_PREG_MAX_W'(disp_rs1);
        entries_d[tail_q].rs2         = BRQ_PREG_MAX_W'(disp_rs2);
        entries_d[tail_q].rs1_rdy     = disp_rs1_rdy | (cdb_valid & (disp_rs1 == cdb_preg));
        entries_d[tail_q].rs2_rdy     = disp_rs2_rdy | (cdb_valid & (disp_rs2 == cdb_preg));
        entries_d[tail_q].pd          = BRQ_PREG_MAX_W'(disp_pd);
        entries_d[tail_q].rob_idx     = BRQ_ROB_MAX_W'(disp_rob_idx);
        tail_d = tail_q + PTR_W'(1'b1);
      end else begin
        tail_d = tail_q;
      end
      count_d = count_q + CNT_W'(disp_fire_s) - CNT_W'(issue_s);
    end
  end

  always_comb begin
    res_valid_d      = issue_s;
    res_mispredict_d = issue_s & mispredict_s;
    wb_valid_d       = issue_s & is_link_s;
    res_rob_idx_d    = issue_s ? entries_q[head_q].rob_idx[ROB_W-1:0] : res_rob_idx_q;
    res_taken_d      = issue_s ? bu_taken : res_taken_q;
    res_target_d     = issue_s ? bu_target : res_target_q;
    wb_preg_d        = issue_s ? entries_q[head_q].pd[PREG_W-1:0] : wb_preg_q;
    wb_data_d        = issue_s ? link_addr(entries_q[head_q].pc) : wb_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      res_valid_q      <= 1'b0;
      res_rob_idx_q    <= '0;
      res_taken_q      <= 1'b0;
      res_target_q     <= 32'd0;
      res_mispredict_q <= 1'b0;
      wb_valid_q       <= 1'b0;
      wb_preg_q        <= '0;
      wb_data_q        <= 32'd0;
    end else begin
      entries_q        <= entries_d;
      head_q           <= head_d;
      tail_q           <= tail_d;
      count_q          <= count_d;
      res_valid_q      <= res_valid_d;
      res_rob_idx_q    <= res_rob_idx_d;
      res_taken_q      <= res_taken_d;
      res_target_q     <= res_target_d;
      res_mispredict_q <= res_mispredict_d;
      wb_valid_q       <= wb_valid_d;
      wb_preg_q        <= wb_preg_d;
      wb_data_q        <= wb_data_d;
    end
  end

  assign res_valid      = res_valid_q;
  assign res_rob_idx    = res_rob_idx_q;
  assign res_taken      = res_taken_q;
  assign res_target     = res_target_q;
  assign res_mispredict = res_mispredict_q;
  assign wb_valid       = wb_valid_q;
  assign wb_preg        = wb_preg_q;
  assign wb_data        = wb_data_q;

endmodule

// File: tb/tb_branch_issue_queue.sv
// Bench for branch_issue_queue: directed scenarios then random traffic, checked against a queue-based model.
module tb_branch_issue_queue;
  import branch_issue_queue_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, flush, disp_valid, disp_ready;
  inst_type_t  disp_inst_type;
  branch_op_t  disp_branch_op;
  logic [31:0] disp_pc, disp_imm, disp_pred_target;
  logic        disp_pred_taken, disp_rs1_rdy, disp_rs2_rdy;
  logic [5:0]  disp_rs1, disp_rs2, disp_pd, cdb_preg, prf_rs1_idx, prf_rs2_idx, wb_preg;
  logic [3:0]  disp_rob_idx, res_rob_idx;
  logic        cdb_valid, bu_taken, res_valid, res_taken, res_mispredict, wb_valid;
  logic [31:0] prf_rs1_data, prf_rs2_data, bu_target, bu_pc, bu_imm, bu_rs1_data, bu_rs2_data;
  logic [31:0] res_target, wb_data;
  branch_op_t  bu_branch_op;
  inst_type_t  bu_inst_type;

  logic [31:0] prf [64];
  int checks = 0;
  int passed = 0;
  int fails  = 0;

  typedef struct {
    int typ; int op; logic [31:0] pc; logic [31:0] imm; bit pt; logic [31:0] ptgt;
    int rs1; int rs2; bit r1; bit r2; int pd; int rob;
  } m_ent_t;
  m_ent_t mq[$];
  bit e_res_valid, e_res_taken, e_res_mispredict, e_wb_valid;
  logic [31:0] e_res_target, e_wb_data;
  int e_res_rob, e_wb_preg;

  always #5 clk = ~clk;

  branch_issue_queue #(.DEPTH(DEPTH), .PREG_W(6), .ROB_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_inst_type(disp_inst_type), .disp_branch_op(disp_branch_op), .disp_pc(disp_pc),
    .disp_imm(disp_imm), .disp_pred_taken(disp_pred_taken), .disp_pred_target(disp_pred_target),
    .disp_rs1(disp_rs1), .disp_rs2(disp_rs2), .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
    .disp_pd(disp_pd), .disp_rob_idx(disp_rob_idx), .cdb_valid(cdb_valid), .cdb_preg(cdb_preg),
    .prf_rs1_idx(prf_rs1_idx), .prf_rs2_idx(prf_rs2_idx), .prf_rs1_data(prf_rs1_data),
    .prf_rs2_data(prf_rs2_data), .bu_taken(bu_taken), .bu_target(bu_target),
    .bu_branch_op(bu_branch_op), .bu_inst_type(bu_inst_type), .bu_pc(bu_pc), .bu_imm(bu_imm),
    .bu_rs1_data(bu_rs1_data), .bu_rs2_data(bu_rs2_data), .res_valid(res_valid),
    .res_rob_idx(res_rob_idx), .res_taken(res_taken), .res_target(res_target),
    .res_mispredict(res_mispredict), .wb_valid(wb_valid), .wb_preg(wb_preg), .wb_data(wb_data)
  );

  // Architectural branch semantics: typ 0=BRANCH 1=JAL 2=JALR; op codes as in the package.
  function automatic bit br_taken(input int typ, input int op, input logic [31:0] a, input logic [31:0] b);
    if (typ != 0) return 1'b1;
    case (op)
      0: return a == b;
      1: return a != b;
      4: return $signed(a) < $signed(b);
      5: return $signed(a) >= $signed(b);
      6: return a < b;
      7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] br_target(input int typ, input logic [31:0] pc, input logic [31:0] imm,
                                            input logic [31:0] a);
    if (typ == 2) return (a + imm) & 32'hFFFF_FFFE;
    return pc + imm;
  endfunction

  assign prf_rs1_data = prf[prf_rs1_idx];
  assign prf_rs2_data = prf[prf_rs2_idx];

  // Stand-in for the external branch unit.
  always_comb begin
    bu_taken  = br_taken(int'(bu_inst_type), int'(bu_branch_op), bu_rs1_data, bu_rs2_data);
    bu_target = br_target(int'(bu_inst_type), bu_pc, bu_imm, bu_rs1_data);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("disp_ready", 32'(disp_ready), 32'(!rst && mq.size() < DEPTH));
    chk("res_valid", 32'(res_valid), 32'(e_res_valid));
    chk("res_mispredict", 32'(res_mispredict), 32'(e_res_mispredict));
    chk("wb_valid", 32'(wb_valid), 32'(e_wb_valid));
    if (e_res_valid) begin
      chk("res_taken", 32'(res_taken), 32'(e_res_taken));
      chk("res_target", res_target, e_res_target);
      chk("res_rob_idx", 32'(res_rob_idx), 32'(e_res_rob));
    end
    if (e_wb_valid) begin
      chk("wb_preg", 32'(wb_preg), 32'(e_wb_preg));
      chk("wb_data", wb_data, e_wb_data);
    end
    if (mq.size() > 0) begin
      chk("prf_rs1_idx", 32'(prf_rs1_idx), 32'(mq[0].rs1));
      chk("prf_rs2_idx", 32'(prf_rs2_idx), 32'(mq[0].rs2));
      chk("bu_pc", bu_pc, mq[0].pc);
      chk("bu_imm", bu_imm, mq[0].imm);
      chk("bu_inst_type", 32'(bu_inst_type), 32'(mq[0].typ));
    end
  endtask

  task automatic model_step();
    bit mis, iss, tk, mp, can_disp;
    logic [31:0] tg;
    m_ent_t h, n;
    mis = e_res_mispredict;
    can_disp = !rst && mq.size() < DEPTH;
    iss = 1'b0; tk = 1'b0; mp = 1'b0; tg = 32'd0;
    if (mq.size() > 0) begin
      h = mq[0];
      iss = (h.typ == 1 || (h.r1 && h.r2)) && !flush && !mis && !rst;
    end
    if (iss) begin
      tk = br_taken(h.typ, h.op, prf[h.rs1], prf[h.rs2]);
      tg = br_target(h.typ, h.pc, h.imm, prf[h.rs1]);
      mp = (tk != h.pt) || (tk && tg != h.ptgt);
    end
    if (rst) begin
      mq.delete();
      e_res_valid = 0; e_res_taken = 0; e_res_mispredict = 0; e_wb_valid = 0;
      e_res_target = 32'd0; e_wb_data = 32'd0; e_res_rob = 0; e_wb_preg = 0;
    end else begin
      e_res_valid = iss;
      e_res_mispredict = iss && mp;
      e_wb_valid = iss && h.typ != 0;
      if (iss) begin
        e_res_taken = tk; e_res_target = tg; e_res_rob = h.rob;
        e_wb_preg = h.pd; e_wb_data = h.pc + 32'd4;
      end
      if (flush || mis) mq.delete();
      else begin
        foreach (mq[i]) begin
          if (cdb_valid && mq[i].rs1 == int'(cdb_preg)) mq[i].r1 = 1'b1;
          if (cdb_valid && mq[i].rs2 == int'(cdb_preg)) mq[i].r2 = 1'b1;
        end
        if (iss) void'(mq.pop_front());
        if (disp_valid && can_disp) begin
          n.typ = int'(disp_inst_type); n.op = int'(disp_branch_op);
          n.pc = disp_pc; n.imm = disp_imm; n.pt = disp_pred_taken; n.ptgt = disp_pred_target;
          n.rs1 = int'(disp_rs1); n.rs2 = int'(disp_rs2);
          n.r1 = disp_rs1_rdy || (cdb_valid && disp_rs1 == cdb_preg);
          n.r2 = disp_rs2_rdy || (cdb_valid && disp_rs2 == cdb_preg);
          n.pd = int'(disp_pd); n.rob = int'(disp_rob_idx);
          mq.push_back(n);
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; flush = 1'b0; disp_valid = 1'b0; cdb_valid = 1'b0; cdb_preg = 6'd0;
  endtask

  task automatic disp(input int typ, input int op, input logic [31:0] pc, input logic [31:0] imm,
                      input bit pt, input logic [31:0] ptgt, input int rs1, input int rs2,
                      input bit r1, input bit r2, input int pd, input int rob);
    disp_valid = 1'b1;
    disp_inst_type = inst_type_t'(2'(typ)); disp_branch_op = branch_op_t'(3'(op));
    disp_pc = pc; disp_imm = imm; disp_pred_taken = pt; disp_pred_target = ptgt;
    disp_rs1 = 6'(rs1); disp_rs2 = 6'(rs2); disp_rs1_rdy = r1; disp_rs2_rdy = r2;
    disp_pd = 6'(pd); disp_rob_idx = 4'(rob);
  endtask

  initial begin
    int ops[6] = '{0, 1, 4, 5, 6, 7};
    for (int i = 0; i < 64; i++) prf[i] = $urandom;
    idle();
    disp(0, 0, 32'h0, 32'h0, 1'b0, 32'h0, 0, 0, 1'b0, 1'b0, 0, 0);
    disp_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    tick();
    chk("reset_res_target", res_target, 32'd0);
    chk("reset_wb_data", wb_data, 32'd0);

    // BEQ equal operands predicted not-taken: mispredict, queue emptied, dispatch in that cycle dropped.
    idle();
    disp(0, 0, 32'h100, 32'h20, 1'b0, 32'h0, 5, 5, 1'b1, 1'b1, 3, 2);
    tick();
    idle(); tick();
    chk("beq_res_valid", 32'(res_valid), 32'd1);
    chk("beq_res_taken", 32'(res_taken), 32'd1);
    chk("beq_res_target", res_target, 32'h120);
    chk("beq_mispredict", 32'(res_mispredict), 32'd1);
    disp(0, 0, 32'h180, 32'h8, 1'b0, 32'h0, 5, 5, 1'b1, 1'b1, 3, 4);
    tick();
    idle(); tick();
    chk("beq_drop_disp", 32'(res_valid), 32'd0);
    chk("beq_empty_ready", 32'(disp_ready), 32'd1);

    // BNE waiting on rs1 until a CDB broadcast.
    prf[10] = 32'd1; prf[11] = 32'd2;
    disp(0, 1, 32'h300, 32'h10, 1'b1, 32'h310, 10, 11, 1'b0, 1'b1, 0, 5);
    tick();
    idle(); tick();
    chk("bne_wait1", 32'(res_valid), 32'd0);
    cdb_valid = 1'b1; cdb_preg = 6'd10;
    tick();
    chk("bne_wait_cdb", 32'(res_valid), 32'd0);
    idle(); tick();
    chk("bne_issue", 32'(res_valid), 32'd1);
    chk("bne_no_mp", 32'(res_mispredict), 32'd0);

    // JAL link writeback, regardless of operand readiness.
    disp(1, 0, 32'h200, 32'h40, 1'b1, 32'h240, 30, 31, 1'b0, 1'b0, 7, 6);
    tick();
    idle(); tick();
    chk("jal_wb_valid", 32'(wb_valid), 32'd1);
    chk("jal_wb_preg", 32'(wb_preg), 32'd7);
    chk("jal_wb_data", wb_data, 32'h204);
    chk("jal_no_mp", 32'(res_mispredict), 32'd0);

    // Fill, wake head, dispatch across the wrap, then prove in-order issue.
    for (int i = 0; i < 4; i++) begin
      disp(0, 0, 32'h400 + 32'(16 * i), 32'h8, 1'b1, 32'h408 + 32'(16 * i), 20 + i, 20 + i, 1'b0, 1'b0, 1, 8 + i);
      tick();
    end
    idle();
    chk("full_not_ready", 32'(disp_ready), 32'd0);
    cdb_valid = 1'b1; cdb_preg = 6'd20;
    tick();
    idle(); tick();
    chk("wake_issue", 32'(res_valid), 32'd1);
    chk("wake_ready", 32'(disp_ready), 32'd1);
    disp(0, 0, 32'h500, 32'h8, 1'b1, 32'h508, 24, 24, 1'b0, 1'b0, 1, 12);
    tick();
    idle(); cdb_valid = 1'b1; cdb_preg = 6'd24;
    tick();
    idle(); tick();
    chk("wrap_order_hold", 32'(res_valid), 32'd0);
    for (int i = 1; i < 4; i++) begin
      cdb_valid = 1'b1; cdb_preg = 6'(20 + i);
      tick();
    end
    idle();
    for (int i = 0; i < 5; i++) tick();

    // Flush against simultaneous dispatch and head issue.
    disp(1, 0, 32'h600, 32'h10, 1'b1, 32'h610, 0, 0, 1'b1, 1'b1, 9, 1);
    tick();
    disp(1, 0, 32'h700, 32'h10, 1'b1, 32'h710, 0, 0, 1'b1, 1'b1, 9, 2);
    flush = 1'b1;
    tick();
    idle();
    chk("flush_res_valid", 32'(res_valid), 32'd0);
    chk("flush_wb_valid", 32'(wb_valid), 32'd0);
    tick();
    chk("flush_empty", 32'(res_valid), 32'd0);

    // Reset with three valid entries and a head about to issue.
    for (int i = 0; i < 3; i++) begin
      disp(2, 0, 32'h800 + 32'(4 * i), 32'h4, 1'b0, 32'h0, 40, 40, 1'b0, 1'b0, 11, 3 + i);
      tick();
    end
    idle(); cdb_valid = 1'b1; cdb_preg = 6'd40;
    tick();
    idle(); rst = 1'b1;
    tick();
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_res_target", res_target, 32'd0);
    chk("rst_wb_preg", 32'(wb_preg), 32'd0);
    chk("rst_disp_ready", 32'(disp_ready), 32'd0);
    idle();
    tick(); tick();
    chk("rst_no_stale", 32'(res_valid), 32'd0);

    // Random traffic with a small preg/value space so wakeups and branch outcomes vary.
    for (int i = 0; i < 64; i++) prf[i] = 32'($urandom_range(0, 3)) - 32'd1;
    for (int c = 0; c < 500; c++) begin
      int typ;
      logic [31:0] pc, imm;
      typ = $urandom_range(0, 2);
      pc  = 32'($urandom_range(0, 255)) << 2;
      imm = 32'($urandom_range(0, 15)) << 2;
      disp(typ, ops[$urandom_range(0, 5)], pc, imm, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0) ? pc + imm : 32'($urandom_range(0, 1023)),
           $urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), $urandom_range(0, 63), $urandom_range(0, 15));
      disp_valid = 1'($urandom_range(0, 1));
      cdb_valid  = 1'($urandom_range(0, 1));
      cdb_preg   = 6'($urandom_range(0, 7));
      flush      = ($urandom_range(0, 15) == 0);
      rst        = ($urandom_range(0, 63) == 0);
      tick();
    end
    idle();
    tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/branch_issue_queue.md
BRANCH_ISSUE_QUEUE -- requirements
Module: branch_issue_queue

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 Parameters (name, default, meaning) SHALL be:
  - DEPTH, 4, queue entries (power of two);
  - PREG_W, 6, physical register index width;
  - ROB_W, 4, ROB index width.
REQ-003 Ports (name, direction, width, meaning) SHALL be:
  - clk, in, 1, clock;
  - rst, in, 1, synchronous active-high reset;
  - flush, in, 1, external pipeline flush;
  - disp_valid, in, 1, dispatch request;
  - disp_ready, out, 1, queue can accept;
  - disp_inst_type, in, inst_type_t, instruction type;
  - disp_branch_op, in, branch_op_t, branch operation;
  - disp_pc / disp_imm, in, 32 each, PC and immediate;
  - disp_pred_taken, in, 1, frontend prediction;
  - disp_pred_target, in, 32, predicted target;
  - disp_rs1 / disp_rs2, in, PREG_W each, source pregs;
  - disp_rs1_rdy / disp_rs2_rdy, in, 1 each, operand ready at dispatch;
  - disp_pd, in, PREG_W, link destination preg;
  - disp_rob_idx, in, ROB_W, ROB tag;
  - cdb_valid, in, 1, CDB broadcast valid;
  - cdb_preg, in, PREG_W, CDB broadcast preg;
  - prf_rs1_idx / prf_rs2_idx, out, PREG_W each, PRF read index;
  - prf_rs1_data / prf_rs2_data, in, 32 each, combinational PRF data;
  - bu_taken, in, 1, branch_unit result;
  - bu_target, in, 32, branch_unit result;
  - bu_branch_op / bu_inst_type / bu_pc / bu_imm / bu_rs1_data / bu_rs2_data, out, operands driven to branch_unit;
  - res_valid, out, 1, resolution valid;
  - res_rob_idx, out, ROB_W, resolved ROB tag;
  - res_taken, out, 1, resolved direction;
  - res_target, out, 32, resolved target;
  - res_mispredict, out, 1, misprediction;
  - wb_valid, out, 1, link writeback valid;
  - wb_preg, out, PREG_W, link destination;
  - wb_data, out, 32, link value.

Function
REQ-004 The queue SHALL be an in-order circular FIFO of DEPTH entries with head pointer, tail pointer and an occupancy count of width $clog2(DEPTH)+1.
REQ-005 disp_ready SHALL equal (count < DEPTH); there is no same-cycle bypass when full.
REQ-006 On disp_valid && disp_ready, the tail entry SHALL be written and the tail SHALL increment modulo DEPTH.
REQ-007 Each entry's ready bit for a source SHALL be set when cdb_valid && cdb_preg == that source, including at the dispatch cycle (disp_rsX_rdy OR CDB match).
REQ-008 Only the head entry SHALL issue, and it issues when it is valid with both sources ready.
  - JAL entries ignore source readiness.
REQ-009 prf_rs1_idx and prf_rs2_idx SHALL be driven combinationally from the head entry.
REQ-010 The bu_* outputs SHALL be driven combinationally from the head entry and the PRF data.
REQ-011 On issue, the head SHALL increment modulo DEPTH, and the count SHALL update by (+dispatch, -issue), with simultaneous dispatch and issue leaving the count unchanged.
REQ-012 Resolution SHALL be registered: an issue in cycle N produces res_valid=1 in cycle N+1 for exactly one cycle, carrying res_taken, res_target and res_rob_idx.
REQ-013 res_mispredict SHALL equal (bu_taken != pred_taken) || (bu_taken && bu_target != pred_target).
REQ-014 For JAL and JALR, wb_valid SHALL be 1 in cycle N+1 with wb_preg = pd and wb_data = pc+4; for BRANCH, wb_valid SHALL be 0.
REQ-015 In any cycle with res_mispredict=1:
  - issue SHALL be suppressed;
  - dispatch SHALL be ignored;
  - all entries, head, tail and count SHALL clear at the clock edge.
REQ-016 flush=1 SHALL clear all entries and pointers at the edge, override dispatch, issue and wakeup, and force res_valid=0 and wb_valid=0 in the next cycle.
REQ-017 Pointer wrap-around from DEPTH-1 to 0 SHALL be seamless; ordering SHALL be preserved across the wrap.

Reset
REQ-018 On rst, the following SHALL be 0 at the next edge:
  - head, tail and count;
  - all entry valid bits;
  - res_valid, res_mispredict, res_taken, res_target and res_rob_idx;
  - wb_valid, wb_preg and wb_data.
REQ-019 While rst is asserted, disp_ready SHALL read 0; reset mid-operation SHALL discard in-flight entries and any pending resolution.

Structure
REQ-020 branch_op_t and inst_type_t SHALL come from the shared types package.
REQ-021 A new brq_entry_t struct SHALL be added to the types package with these fields:
  - valid;
  - inst_type, branch_op;
  - pc, imm;
  - pred_taken, pred_target;
  - rs1, rs1_rdy, rs2, rs2_rdy;
  - pd, rob_idx.
REQ-022 branch_unit SHALL be instantiated externally and connected via the bu_* ports; no sub-module is required inside this block.

Verification
REQ-023 Dispatch a BEQ with rs1=rs2=5 ready and PRF values equal, pred_taken=0, pc=0x100, imm=0x20 -> res_valid in cycle N+1 with res_taken=1, res_target=0x120, res_mispredict=1, and the queue empty in the following cycle.
REQ-024 Dispatch a BNE with rs1 not ready, then cdb_valid with cdb_preg=rs1 two cycles later -> issue in the CDB cycle+1, never before it.
REQ-025 Dispatch a JAL with pc=0x200, pd=7, pred_taken=1, pred_target=0x240 and imm=0x40 -> wb_valid=1, wb_preg=7, wb_data=0x204, res_mispredict=0.
REQ-026 Fill 4 entries with unready operands -> disp_ready=0; then wake the head -> a one-cycle issue, disp_ready=1, and a fifth dispatch wraps to slot 0.
REQ-027 Assert flush in the same cycle as a dispatch and a head issue -> count=0 next cycle, res_valid=0, no writeback.
REQ-028 Assert rst with 3 entries valid -> all outputs 0 at the next edge and no stale resolution after deassertion.
